ws2812b_frame_sequencer: RTL and testbench

WS2812B_FRAME_SEQUENCER -- requirements
Module: ws2812b_frame_sequencer

---
 rtl/ws2812b_pkg.sv | 16 +
 rtl/ws2812b_period_timer.sv | 36 +++
 rtl/ws2812b_frame_sequencer.sv | 126 ++++++++++++
 tb/tb_ws2812b_frame_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// Shared state encoding, pixel width and default timing for the WS2812B frame sequencer.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    LATCH
  } state_e;

  localparam int unsigned GRB_WIDTH                     = 24;
  localparam int unsigned BIT_CNT_W                     = $clog2(GRB_WIDTH);
  localparam int unsigned DEFAULT_BIT_PERIOD_CLK_COUNTS = 62;
  localparam int unsigned DEFAULT_LATCH_CLK_COUNTS      = 2600;

endpackage

// File: rtl/ws2812b_period_timer.sv
// Loadable down counter with terminal-count flag; times both bit periods and the latch gap.
module ws2812b_period_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == '0);

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Streams LED_COUNT GRB pixels MSB-first to a WS2812B bit encoder, then holds the line low to latch.
module ws2812b_frame_sequencer
  import ws2812b_pkg::*;
#(
  parameter int unsigned LED_COUNT             = 8,
  parameter int unsigned BIT_PERIOD_CLK_COUNTS = DEFAULT_BIT_PERIOD_CLK_COUNTS,
  parameter int unsigned LATCH_CLK_COUNTS      = DEFAULT_LATCH_CLK_COUNTS,
  localparam int unsigned AW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [AW-1:0]        led_addr,
  input  logic [GRB_WIDTH-1:0] led_color,
  output logic                 trigger,
  output logic                 bit_to_code,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned TMAX = (BIT_PERIOD_CLK_COUNTS > LATCH_CLK_COUNTS) ?
                                 BIT_PERIOD_CLK_COUNTS : LATCH_CLK_COUNTS;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]        BIT_RELOAD   = TW'(BIT_PERIOD_CLK_COUNTS - 1);
  localparam logic [TW-1:0]        LATCH_RELOAD = TW'(LATCH_CLK_COUNTS - 1);
  localparam logic [AW-1:0]        LAST_LED     = AW'(LED_COUNT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(GRB_WIDTH - 1);

  state_e                 state_q, state_d;
  logic [GRB_WIDTH-1:0]   shreg_q, shreg_d;
  logic [AW-1:0]          led_cnt_q, led_cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic                   tmr_load, tmr_en, tmr_tc;
  logic [TW-1:0]          tmr_load_val, tmr_count;

  ws2812b_period_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .en_i      (tmr_en),
    .count_o   (tmr_count),
    .tc_o      (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    led_cnt_d    = led_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = BIT_RELOAD;
    tmr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d   = SEND;
        shreg_d   = led_color;
        led_cnt_d = '0;
        bit_cnt_d = '0;
        tmr_load  = 1'b1;
      end
      SEND: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (bit_cnt_q != LAST_BIT) begin
            shreg_d   = {shreg_q[GRB_WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (led_cnt_q != LAST_LED) begin
            // led_addr has pointed at the next pixel for the whole LED, so led_color is already valid
            shreg_d   = led_color;
            led_cnt_d = led_cnt_q + AW'(1);
            bit_cnt_d = '0;
          end else begin
            state_d      = LATCH;
            tmr_load_val = LATCH_RELOAD;
            shreg_d      = '0;
            led_cnt_d    = '0;
            bit_cnt_d    = '0;
          end
        end
      end
      LATCH: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      led_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      led_cnt_q <= led_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // The timer reloads to BIT_RELOAD on each bit start, so that value is period position 0.
  assign trigger     = (state_q == SEND) && (tmr_count == BIT_RELOAD);
  assign bit_to_code = (state_q == SEND) && shreg_q[GRB_WIDTH-1];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == LATCH) && tmr_tc;
  assign led_addr    = (state_q != SEND)       ? '0 :
                       (led_cnt_q == LAST_LED) ? led_cnt_q :
                                                 led_cnt_q + AW'(1);

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Directed bench: a 2-LED default-timing chain and a 1-LED fast-timing chain, checked cycle by cycle.
`timescale 1ns/1ps
module tb_ws2812b_frame_sequencer;

  localparam int N        = 2;
  localparam int P        = 62;
  localparam int L        = 2600;
  localparam int SEND_END = 1 + 24 * N * P;
  localparam int T        = 1 + 24 * N * P + L;
  localparam int SP       = 4;
  localparam int SL       = 3;
  localparam int S_END    = 1 + 24 * SP;
  localparam int ST       = 1 + 24 * SP + SL;

  logic        clk = 1'b0;
  logic        rst, start, start_s;
  logic [0:0]  led_addr, led_addr_s;
  logic [23:0] led_color, led_color_s;
  logic        trigger, bit_to_code, busy, done;
  logic        trigger_s, bit_to_code_s, busy_s, done_s;

  logic [23:0] mem   [0:1];
  logic [23:0] mem_s [0:1];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    led_color   <= mem[led_addr];
    led_color_s <= mem_s[led_addr_s];
  end

  ws2812b_frame_sequencer #(
    .LED_COUNT            (N),
    .BIT_PERIOD_CLK_COUNTS(P),
    .LATCH_CLK_COUNTS     (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .led_addr   (led_addr),
    .led_color  (led_color),
    .trigger    (trigger),
    .bit_to_code(bit_to_code),
    .busy       (busy),
    .done       (done)
  );

  ws2812b_frame_sequencer #(
    .LED_COUNT            (1),
    .BIT_PERIOD_CLK_COUNTS(SP),
    .LATCH_CLK_COUNTS     (SL)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .start      (start_s),
    .led_addr   (led_addr_s),
    .led_color  (led_color_s),
    .trigger    (trigger_s),
    .bit_to_code(bit_to_code_s),
    .busy       (busy_s),
    .done       (done_s)
  );

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Called just after the edge that sampled start; cycle 1 is FETCH.
  task automatic run_frame(input string name, input logic [47:0] exp_bits, input bit hold,
                           input int p1, input int p2);
    int c, k, bitn, led, done_cyc, ntrig, e_trig, e_bit, e_addr, e_busy;
    bit in_send, fin;
    logic exp_trig, exp_bit;
    logic [0:0] exp_addr;
    c = 0; fin = 0; done_cyc = -1; ntrig = 0;
    e_trig = 0; e_bit = 0; e_addr = 0; e_busy = 0;
    while (!fin && c < T + 20) begin
      @(negedge clk);
      c++;
      start    = hold || (c == p1) || (c == p2);
      in_send  = (c >= 2) && (c <= SEND_END);
      exp_trig = 1'b0; exp_bit = 1'b0; exp_addr = 1'b0;
      if (in_send) begin
        k        = c - 2;
        bitn     = k / P;
        led      = bitn / 24;
        exp_trig = (k % P) == 0;
        exp_bit  = exp_bits[47 - bitn];
        exp_addr = (led + 1 > N - 1) ? 1'(N - 1) : 1'(led + 1);
      end
      if (trigger === 1'b1) ntrig++;
      if (trigger !== exp_trig) e_trig++;
      if (bit_to_code !== exp_bit) e_bit++;
      if (led_addr !== exp_addr) e_addr++;
      if (busy !== 1'b1) e_busy++;
      if (done === 1'b1) begin
        done_cyc = c;
        fin      = 1;
      end
    end
    check_eq({name, "_done_cycle"}, done_cyc, T);
    check_eq({name, "_trigger_count"}, ntrig, 2 * 24);
    check_eq({name, "_trigger_timing_errs"}, e_trig, 0);
    check_eq({name, "_bit_errs"}, e_bit, 0);
    check_eq({name, "_led_addr_errs"}, e_addr, 0);
    check_eq({name, "_busy_errs"}, e_busy, 0);
  endtask

  task automatic idle_quiet(input string name, input int cycles);
    int act;
    act = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || trigger !== 1'b0) act++;
    end
    check_eq(name, act, 0);
  endtask

  task automatic run_small();
    int c, k, done_cyc, ntrig, e_trig, e_bit, e_addr;
    bit fin;
    logic [23:0] px;
    logic exp_trig, exp_bit;
    px = 24'hC0FFEE;
    c = 0; fin = 0; done_cyc = -1; ntrig = 0; e_trig = 0; e_bit = 0; e_addr = 0;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    while (!fin && c < ST + 20) begin
      @(negedge clk);
      c++;
      start_s  = 1'b0;
      exp_trig = 1'b0; exp_bit = 1'b0;
      if (c >= 2 && c <= S_END) begin
        k        = c - 2;
        exp_trig = (k % SP) == 0;
        exp_bit  = px[23 - k / SP];
      end
      if (trigger_s === 1'b1) ntrig++;
      if (trigger_s !== exp_trig) e_trig++;
      if (bit_to_code_s !== exp_bit) e_bit++;
      if (led_addr_s !== 1'b0) e_addr++;
      if (done_s === 1'b1) begin
        done_cyc = c;
        fin      = 1;
      end
    end
    check_eq("small_done_cycle", done_cyc, 100);
    check_eq("small_trigger_count", ntrig, 24);
    check_eq("small_trigger_timing_errs", e_trig, 0);
    check_eq("small_bit_errs", e_bit, 0);
    check_eq("small_led_addr_nonzero", e_addr, 0);
    @(negedge clk);
    check_eq("small_idle_after_done", busy_s, 1'b0);
  endtask

  initial begin
    int c, e_rst;
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    mem[0]   = 24'hFF0000; mem[1]   = 24'h000001;
    mem_s[0] = 24'hC0FFEE; mem_s[1] = 24'h123456;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_trigger", trigger, 1'b0);
    check_eq("rst_bit_to_code", bit_to_code, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_led_addr", led_addr, 1'b0);
    check_eq("rst_small_busy", busy_s, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_small();

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    run_frame("frame_a", 48'hFF0000_000001, 1'b0, 0, 0);
    idle_quiet("frame_a_quiet_after", 20);

    mem[0] = 24'h96A53C; mem[1] = 24'h5AC30F;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    run_frame("frame_b", 48'h96A53C_5AC30F, 1'b0, 500, SEND_END + 100);
    idle_quiet("frame_b_ignored_starts", 20);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    run_frame("cont_1", 48'h96A53C_5AC30F, 1'b1, 0, 0);
    @(negedge clk);
    check_eq("cont_idle_gap_busy", busy, 1'b0);
    @(posedge clk);
    run_frame("cont_2", 48'h96A53C_5AC30F, 1'b0, 0, 0);
    idle_quiet("cont_quiet_after", 10);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    c = 0;
    while (c < 2 + 29 * P + 10) begin
      @(negedge clk);
      c++;
      start = 1'b0;
    end
    check_eq("pre_rst_busy", busy, 1'b1);
    check_eq("pre_rst_led_addr", led_addr, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_trigger", trigger, 1'b0);
    check_eq("mid_rst_bit_to_code", bit_to_code, 1'b0);
    check_eq("mid_rst_led_addr", led_addr, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    e_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (trigger !== 1'b0 || busy !== 1'b0) e_rst++;
    end
    check_eq("rst_hold_activity", e_rst, 0);
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk);
    run_frame("restart", 48'h96A53C_5AC30F, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
